sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 128 ++++++++++++
 tb/tb_sw_debounce.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - synchronizer plus whole-vector debouncer for board switches
// Optional build macro SW_DEBOUNCE_EDGE_EN adds per-bit rise/fall strobes.
module sw_debounce #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_sw,
    output logic             o_wren,
`ifdef SW_DEBOUNCE_EDGE_EN
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
`endif
    output logic             o_busy
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
    logic [WIDTH-1:0]                  sync_q;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic             wren_q, wren_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Plain flop chain; stage 0 may go metastable, later stages give it time to settle.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], i_sw_raw};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        wren_d  = 1'b0;
        rise_d  = '0;
        fall_d  = '0;
        case (state_q)
            STABLE: begin
                if (sync_q != sw_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Returning to the accepted value wins over everything, then any new change restarts timing.
                if (sync_q == sw_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    sw_d    = cand_q;
                    wren_d  = 1'b1;
                    rise_d  = cand_q & ~sw_q;
                    fall_d  = ~cand_q & sw_q;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
        busy_d = (state_d == COUNT);
    end

    assign o_sw   = sw_q;
    assign o_wren = wren_q;
    assign o_busy = busy_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    logic unused_edge;
    assign unused_edge = ^{rise_q, fall_q};
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - randomized bench for sw_debounce against a run-length reference model
module tb_sw_debounce;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int DB = 4;

    logic          i_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  i_sw_raw = '0;
    logic [W-1:0]  o_sw;
    logic          o_wren;
    logic          o_busy;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [W-1:0]  o_rise;
    logic [W-1:0]  o_fall;
`endif

    sw_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_sw_raw(i_sw_raw),
        .o_sw    (o_sw),
        .o_wren  (o_wren),
`ifdef SW_DEBOUNCE_EDGE_EN
        .o_rise  (o_rise),
        .o_fall  (o_fall),
`endif
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    int pulses = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the synchronized value seen at edge k is the raw sample taken SS edges earlier;
    // a value is accepted when it has been seen on DB+1 consecutive edges and differs from o_sw.
    logic [W-1:0] samples[$];
    logic [W-1:0] m_sw, m_prev_s, m_rise, m_fall, m_s;
    logic         m_wren, m_busy, m_fire;
    int           m_run, m_n;

    always @(posedge i_clk) begin
        ecnt++;
        if (!rst_n) begin
            samples.delete();
            m_sw = '0; m_prev_s = '0; m_rise = '0; m_fall = '0;
            m_wren = 1'b0; m_busy = 1'b0; m_run = 1;
        end else begin
            samples.push_back(i_sw_raw);
            m_n = samples.size();
            m_s = (m_n - 1 - SS >= 0) ? samples[m_n-1-SS] : '0;
            if (m_s == m_prev_s) m_run++;
            else m_run = 1;
            m_prev_s = m_s;
            m_fire = (m_run == DB + 1) && (m_s != m_sw);
            m_busy = (m_s != m_sw) && !m_fire;
            m_wren = m_fire;
            if (m_fire) begin
                m_rise = m_s & ~m_sw;
                m_fall = ~m_s & m_sw;
                m_sw   = m_s;
            end else begin
                m_rise = '0;
                m_fall = '0;
            end
        end
    end

    always @(negedge i_clk) begin
        check("m_sw", o_sw, m_sw);
        check("m_wren", {31'd0, o_wren}, {31'd0, m_wren});
        check("m_busy", {31'd0, o_busy}, {31'd0, m_busy});
`ifdef SW_DEBOUNCE_EDGE_EN
        check("m_rise", o_rise, m_rise);
        check("m_fall", o_fall, m_fall);
`endif
        if (o_wren) pulses++;
    end

    task automatic drive(input logic [W-1:0] v);
        @(negedge i_clk);
        i_sw_raw = v;
    endtask

    task automatic wait_to(input int t);
        while (ecnt < t) @(negedge i_clk);
    endtask

    int n0, p0;
    logic [W-1:0] rv;

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_sw", o_sw, '0);
        check("rst_wren", {31'd0, o_wren}, '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            check("idle_sw", o_sw, '0);
            check("idle_wren", {31'd0, o_wren}, '0);
            check("idle_busy", {31'd0, o_busy}, '0);
        end

        // Three-cycle glitch must be rejected
        p0 = pulses;
        drive(32'h1);
        repeat (2) @(negedge i_clk);
        drive(32'h0);
        repeat (12) @(negedge i_clk);
        check("glitch_pulses", 32'(pulses - p0), 32'd0);
        check("glitch_sw", o_sw, 32'h0);
        check("glitch_busy", {31'd0, o_busy}, '0);

        // Bounce then hold
        p0 = pulses;
        drive(32'h1);
        drive(32'h0);
        drive(32'h1);
        n0 = ecnt + 1;
        wait_to(n0 + 5);
        check("bounce_wren_early", {31'd0, o_wren}, '0);
        wait_to(n0 + 6);
        check("bounce_wren", {31'd0, o_wren}, 32'd1);
        check("bounce_sw", o_sw, 32'h1);
        wait_to(n0 + 7);
        check("bounce_wren_late", {31'd0, o_wren}, '0);
        check("bounce_pulses", 32'(pulses - p0), 32'd1);

        // Second bit changing mid-count restarts timing
        drive(32'h0);
        repeat (10) @(negedge i_clk);
        p0 = pulses;
        drive(32'h1);
        @(negedge i_clk);
        drive(32'h11);
        n0 = ecnt + 1;
        wait_to(n0 + 5);
        check("restart_sw_early", o_sw, 32'h0);
        wait_to(n0 + 6);
        check("restart_wren", {31'd0, o_wren}, 32'd1);
        check("restart_sw", o_sw, 32'h11);
        wait_to(n0 + 9);
        check("restart_pulses", 32'(pulses - p0), 32'd1);

        // Basic latency and busy window
        drive(32'h0);
        repeat (10) @(negedge i_clk);
        drive(32'hA5);
        n0 = ecnt + 1;
        wait_to(n0 + 3);
        check("a5_busy3", {31'd0, o_busy}, 32'd1);
        wait_to(n0 + 4);
        check("a5_busy4", {31'd0, o_busy}, 32'd1);
        wait_to(n0 + 5);
        check("a5_busy5", {31'd0, o_busy}, 32'd1);
        check("a5_wren5", {31'd0, o_wren}, '0);
        wait_to(n0 + 6);
        check("a5_wren6", {31'd0, o_wren}, 32'd1);
        check("a5_sw6", o_sw, 32'hA5);
        wait_to(n0 + 7);
        check("a5_wren7", {31'd0, o_wren}, '0);
        check("a5_busy7", {31'd0, o_busy}, '0);

`ifdef SW_DEBOUNCE_EDGE_EN
        drive(32'h0F);
        repeat (10) @(negedge i_clk);
        drive(32'hF0);
        n0 = ecnt + 1;
        wait_to(n0 + 6);
        check("edge_rise", o_rise, 32'hF0);
        check("edge_fall", o_fall, 32'h0F);
        wait_to(n0 + 7);
        check("edge_rise_off", o_rise, '0);
        check("edge_fall_off", o_fall, '0);
`endif

        // Randomized segments drawn from a small value pool so repeats occur
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 5))
                0: rv = 32'h0;
                1: rv = 32'h1;
                2: rv = 32'h11;
                3: rv = 32'hA5;
                4: rv = 32'hF0;
                default: rv = $urandom;
            endcase
            drive(rv);
            repeat ($urandom_range(0, 7)) @(negedge i_clk);
        end

        // Reset mid-count discards the candidate
        drive(32'h55);
        repeat (10) @(negedge i_clk);
        check("pre_rst_sw", o_sw, 32'h55);
        drive(32'h3C);
        repeat (3) @(negedge i_clk);
        check("midcount_busy", {31'd0, o_busy}, 32'd1);
        #2 rst_n = 1'b0;
        i_sw_raw = '0;
        #1;
        check("async_rst_sw", o_sw, '0);
        check("async_rst_busy", {31'd0, o_busy}, '0);
        p0 = pulses;
        repeat (3) @(negedge i_clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge i_clk);
        check("post_rst_pulses", 32'(pulses - p0), 32'd0);
        check("post_rst_sw", o_sw, '0);

        // Non-zero switches at reset release are a normal change
        #2 rst_n = 1'b0;
        i_sw_raw = 32'h3C;
        repeat (2) @(negedge i_clk);
        #2 rst_n = 1'b1;
        n0 = ecnt + 1;
        wait_to(n0 + 5);
        check("release_wren_early", {31'd0, o_wren}, '0);
        wait_to(n0 + 6);
        check("release_wren", {31'd0, o_wren}, 32'd1);
        check("release_sw", o_sw, 32'h3C);
        repeat (3) @(negedge i_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
